// File: rtl/im_pkg.sv
// Shared encodings for the IM memory-access stage: access sizes,
// FSM states, byte-enable patterns and the writeback bundle layout.
// Big-endian lanes: byte-enable bit 3 covers data bits 31:24.
package im_pkg;

  localparam logic [1:0] SZ_WORD = 2'b00;
  localparam logic [1:0] SZ_HALF = 2'b01;
  localparam logic [1:0] SZ_BYTE = 2'b10;

  localparam logic [3:0] BE_WORD    = 4'b1111;
  localparam logic [3:0] BE_HALF_HI = 4'b1100;
  localparam logic [3:0] BE_HALF_LO = 4'b0011;
  localparam logic [3:0] BE_BYTE0   = 4'b1000;

  typedef enum logic {
    ST_IDLE   = 1'b0,
    ST_ACCESS = 1'b1
  } state_t;

  typedef struct packed {
    logic [31:0] data;
    logic [31:0] pc;
    logic [4:0]  rd;
    logic        write;
    logic        upc;
    logic        aerr;
    logic        berr;
  } wb_t;

  // Encoding 11 is reserved and behaves as a word access.
  function automatic logic [1:0] norm_size(input logic [1:0] sz);
    return (sz == 2'b11) ? SZ_WORD : sz;
  endfunction

endpackage

// File: rtl/im_mem_access_load_align.sv
// Load lane selection and sign/zero extension of the data-memory read word.
// Ports: rdata (raw bus word), lane (byte offset within the word), size,
//        sign_ext (1 = sign-extend), data (extended 32-bit load result).
module im_load_align
  import im_pkg::*;
(
  input  logic [31:0] rdata,
  input  logic [1:0]  lane,
  input  logic [1:0]  size,
  input  logic        sign_ext,
  output logic [31:0] data
);

  logic [7:0]  byte_sel;
  logic [15:0] half_sel;

  always_comb begin
    byte_sel = 8'h00;
    half_sel = 16'h0000;
    data     = 32'h0;
    // Lane 0 is the most significant byte (big-endian).
    case (lane)
      2'd0:    byte_sel = rdata[31:24];
      2'd1:    byte_sel = rdata[23:16];
      2'd2:    byte_sel = rdata[15:8];
      default: byte_sel = rdata[7:0];
    endcase
    half_sel = lane[1] ? rdata[15:0] : rdata[31:16];
    case (size)
      SZ_BYTE: data = {{24{sign_ext & byte_sel[7]}}, byte_sel};
      SZ_HALF: data = {{16{sign_ext & half_sel[15]}}, half_sel};
      default: data = rdata;
    endcase
  end

endmodule

// File: rtl/im_mem_access.sv
// IM stage: completes the IX/IM bundle against data memory over req/ack,
// with big-endian store steering, load extension and an ack timeout.
// Ports: bundle in (valid_in..update_pc_in), stall_out, dmem_* bus,
//        registered writeback bundle (wb_*, pc_out, update_pc_out), error pulses.
// Optional: define IM_ALIGN_CHECK_EN to reject misaligned half/word accesses.
module im_mem_access
  import im_pkg::*;
#(
  parameter int unsigned ACK_TIMEOUT = 255
) (
  input  logic        clk,
  input  logic        rst_n,
  input  logic        valid_in,
  input  logic [31:0] pc_in,
  input  logic [31:0] O_in,
  input  logic [31:0] B_in,
  input  logic [1:0]  access_size_in,
  input  logic        rw_in,
  input  logic        memory_sign_extend_in,
  input  logic        res_data_sel_in,
  input  logic [4:0]  rt_in,
  input  logic [4:0]  rd_in,
  input  logic        dest_reg_sel_in,
  input  logic        write_to_reg_in,
  input  logic        update_pc_in,
  output logic        stall_out,
  output logic        dmem_req,
  output logic        dmem_we,
  output logic [31:0] dmem_addr,
  output logic [31:0] dmem_wdata,
  output logic [3:0]  dmem_be,
  input  logic        dmem_ack,
  input  logic [31:0] dmem_rdata,
  output logic        wb_valid,
  output logic        wb_write,
  output logic        update_pc_out,
  output logic [31:0] wb_data,
  output logic [31:0] pc_out,
  output logic [4:0]  wb_rd,
  output logic        align_err,
  output logic        bus_err
);

  state_t      state, state_nxt;
  logic [31:0] cnt;
  logic [31:0] addr_q, wdata_q, o_q, pc_q;
  logic [3:0]  be_q;
  logic [1:0]  size_q, lane_q;
  logic        we_q, req_q, load_q, sx_q, wtr_q, upc_q;
  logic [4:0]  rd_q;
  logic        wb_vld_q, pend_vld;
  wb_t         wb_q, pend_q, imm_res, mem_res;
  logic [31:0] load_data;

  logic        accept, mem_op, misalign, issue, imm;
  logic        ack_done, timeout_hit, mem_done;
  logic [1:0]  size_eff, lane_eff;
  logic [3:0]  be_eff;
  logic [31:0] wdata_eff;

  assign size_eff = norm_size(access_size_in);
  assign accept   = valid_in && !stall_out;
  assign mem_op   = rw_in || res_data_sel_in;

`ifdef IM_ALIGN_CHECK_EN
  assign misalign = ((size_eff == SZ_HALF) && O_in[0]) ||
                    ((size_eff == SZ_WORD) && (O_in[1:0] != 2'b00));
`else
  assign misalign = 1'b0;
`endif

  assign issue = accept && mem_op && !misalign;
  // Completions that need no bus cycle: non-memory ops and rejected accesses.
  assign imm   = accept && !issue;

  assign ack_done    = (state == ST_ACCESS) && dmem_ack;
  assign timeout_hit = (state == ST_ACCESS) && !dmem_ack && (ACK_TIMEOUT != 0) &&
                       (cnt == ACK_TIMEOUT - 1);
  assign mem_done    = ack_done || timeout_hit;
  assign stall_out   = (state == ST_ACCESS) && !dmem_ack && !timeout_hit;

  // Misaligned low address bits are dropped here, forcing natural alignment.
  always_comb begin
    lane_eff  = 2'b00;
    be_eff    = BE_WORD;
    wdata_eff = B_in;
    case (size_eff)
      SZ_BYTE: begin
        lane_eff  = O_in[1:0];
        be_eff    = BE_BYTE0 >> O_in[1:0];
        wdata_eff = {4{B_in[7:0]}};
      end
      SZ_HALF: begin
        lane_eff  = {O_in[1], 1'b0};
        be_eff    = O_in[1] ? BE_HALF_LO : BE_HALF_HI;
        wdata_eff = {2{B_in[15:0]}};
      end
      default: ;
    endcase
  end

  im_load_align u_load_align (
    .rdata    (dmem_rdata),
    .lane     (lane_q),
    .size     (size_q),
    .sign_ext (sx_q),
    .data     (load_data)
  );

  always_comb begin
    imm_res       = '0;
    imm_res.data  = O_in;
    imm_res.pc    = pc_in;
    imm_res.rd    = dest_reg_sel_in ? rd_in : rt_in;
    imm_res.write = write_to_reg_in && !misalign;
    imm_res.upc   = update_pc_in;
    imm_res.aerr  = misalign;

    mem_res       = '0;
    mem_res.data  = load_q ? load_data : o_q;
    mem_res.pc    = pc_q;
    mem_res.rd    = rd_q;
    mem_res.write = wtr_q && !timeout_hit;
    mem_res.upc   = upc_q;
    mem_res.berr  = timeout_hit;
  end

  always_ff @(posedge clk or negedge rst_n) begin
    if (!rst_n) state <= ST_IDLE;
    else        state <= state_nxt;
  end

  always_comb begin
    state_nxt = state;
    case (state)
      ST_IDLE:   if (issue) state_nxt = ST_ACCESS;
      ST_ACCESS: if (mem_done) state_nxt = issue ? ST_ACCESS : ST_IDLE;
      default:   state_nxt = ST_IDLE;
    endcase
  end

  always_ff @(posedge clk or negedge rst_n) begin
    if (!rst_n) begin
      addr_q <= '0; wdata_q <= '0; o_q <= '0; pc_q <= '0; be_q <= '0;
      size_q <= '0; lane_q <= '0; we_q <= 1'b0; req_q <= 1'b0;
      load_q <= 1'b0; sx_q <= 1'b0; wtr_q <= 1'b0; upc_q <= 1'b0; rd_q <= '0;
      cnt <= '0; wb_vld_q <= 1'b0; wb_q <= '0; pend_vld <= 1'b0; pend_q <= '0;
    end else begin
      if (issue) begin
        addr_q  <= {O_in[31:2], 2'b00};
        be_q    <= be_eff;
        wdata_q <= wdata_eff;
        we_q    <= rw_in;
        size_q  <= size_eff;
        lane_q  <= lane_eff;
        load_q  <= !rw_in;
        sx_q    <= memory_sign_extend_in;
        o_q     <= O_in;
        pc_q    <= pc_in;
        rd_q    <= dest_reg_sel_in ? rd_in : rt_in;
        wtr_q   <= write_to_reg_in;
        upc_q   <= update_pc_in;
      end

      if (issue)         req_q <= 1'b1;
      else if (mem_done) req_q <= 1'b0;

      if (issue)                   cnt <= '0;
      else if (state == ST_ACCESS) cnt <= cnt + 32'd1;

      // A bundle accepted on the edge a memory op completes would collide with
      // that completion on the writeback port; it waits one cycle in pend_q.
      // Results therefore always leave in program order.
      if (mem_done) begin
        wb_vld_q <= 1'b1;
        wb_q     <= mem_res;
        pend_vld <= imm;
        if (imm) pend_q <= imm_res;
      end else if (pend_vld) begin
        wb_vld_q <= 1'b1;
        wb_q     <= pend_q;
        pend_vld <= imm;
        if (imm) pend_q <= imm_res;
      end else if (imm) begin
        wb_vld_q <= 1'b1;
        wb_q     <= imm_res;
      end else begin
        wb_vld_q   <= 1'b0;
        wb_q.write <= 1'b0;
        wb_q.aerr  <= 1'b0;
        wb_q.berr  <= 1'b0;
      end
    end
  end

  assign dmem_req      = req_q;
  assign dmem_we       = we_q;
  assign dmem_addr     = addr_q;
  assign dmem_wdata    = wdata_q;
  assign dmem_be       = be_q;
  assign wb_valid      = wb_vld_q;
  assign wb_write      = wb_q.write;
  assign wb_data       = wb_q.data;
  assign pc_out        = wb_q.pc;
  assign wb_rd         = wb_q.rd;
  assign update_pc_out = wb_q.upc;
  assign align_err     = wb_q.aerr;
  assign bus_err       = wb_q.berr;

endmodule

// File: doc/im_mem_access.md
# im_mem_access

Memory-stage (IM) access controller; consumes the instruction bundle latched by the IX/IM pipeline register and completes it against data memory. Performs byte/halfword/word loads and stores over a req/ack data-memory handshake with big-endian lane steering and load sign/zero extension. Stalls upstream while an access is outstanding and presents a registered result bundle to writeback.

## Interface
- `ACK_TIMEOUT`, default 255: max cycles in ACCESS awaiting ack; 0 = no timeout.
- `clk  in  1`: clock, all state updates on posedge.
- `rst_n  in  1`: asynchronous, active-low reset.
- `valid_in  in  1`: IX/IM bundle valid.
- `pc_in, O_in, B_in  in  32 each`: PC, ALU result/address, store data.
- `access_size_in  in  2`: 00 word, 01 halfword, 10 byte, 11 treated as word.
- `rw_in  in  1`: 1 store, 0 load/no access.
- `memory_sign_extend_in  in  1`: 1 sign-extend loads, 0 zero-extend.
- `res_data_sel_in  in  1`: 1 result from memory (load).
- `rt_in, rd_in  in  5 each`; `dest_reg_sel_in  in  1`: 1 selects rd, 0 rt.
- `write_to_reg_in, update_pc_in  in  1 each`.
- `stall_out  out  1`: upstream must hold bundle.
- `dmem_req, dmem_we  out  1 each`; `dmem_addr  out  32` (word-aligned); `dmem_wdata  out  32`; `dmem_be  out  4` (bit 3 = bits 31:24).
- `dmem_ack  in  1`; `dmem_rdata  in  32`.
- `wb_valid, wb_write, update_pc_out  out  1 each`; `wb_data, pc_out  out  32`; `wb_rd  out  5`.
- `align_err, bus_err  out  1 each`: one-cycle error pulses.

## Operation
- Accept at any posedge with `valid_in && !stall_out`. Memory op = `rw_in || res_data_sel_in`.
- FSM IDLE/ACCESS. Non-memory op: stay IDLE; wb_* registered at accept edge, `wb_data = O_in`.
- Memory op: enter ACCESS; latch addr/lanes/control; assert `dmem_req` (registered), `dmem_we = rw_in`.
- ACCESS: hold all dmem_* stable until `dmem_ack` sampled high; at that edge drop req, `wb_valid=1`, load data in `wb_data` (store: `wb_data = O`), return IDLE, or accept next bundle at the same edge.
- Store steering: byte `wdata={4{B[7:0]}}`, `be=4'b1000>>addr[1:0]`; half `{2{B[15:0]}}`, be 1100 (addr[1]=0) / 0011; word be 1111.
- Load: byte lane addr[1:0]=0 → rdata[31:24]; half addr[1]=0 → [31:16]; extend per latched sign flag.
- `wb_rd = dest_reg_sel ? rd : rt`; `wb_write = write_to_reg && !error`; pc/update_pc pass through.
- Timeout: counter counts ACCESS cycles; on reaching ACK_TIMEOUT without ack → drop req, `wb_valid=1`, `wb_write=0`, `bus_err=1` one cycle, IDLE. Counter clears on entry to ACCESS.

## Timing
- `stall_out = (state==ACCESS) && !dmem_ack && !timeout_hit` (combinational).
- Non-mem latency 1 edge; memory latency 1 edge + ack wait; back-to-back throughput 1/cycle for non-mem.
- Ack in first ACCESS cycle allowed (single-cycle access). Ack outside ACCESS ignored.
- `wb_valid`, error pulses last exactly one cycle unless a new completion follows.
- Reset (any time, incl. mid-ACCESS): all outputs 0, state IDLE, counter 0; req drops immediately, transaction abandoned.

## Configuration
- `IM_ALIGN_CHECK_EN` defined: half with addr[0]=1 or word with addr[1:0]≠0 issues no request; at accept edge `wb_valid=1`, `wb_write=0`, `align_err=1`.
- Undefined: offending low address bits ignored (forced aligned), access proceeds; `align_err` tied 0.

## Structure
- Package `im_pkg`: access-size encodings, FSM state enum, byte-enable constants.
- Sub-module `im_load_align`: combinational lane select + sign/zero extension of `dmem_rdata`.

## Test plan
- Non-mem op O=0x1234_5678, rd=5, dest_reg_sel=1 → next edge wb_valid=1, wb_data=0x1234_5678, wb_rd=5, no req.
- Load byte addr 0x103, sign=1, rdata=0x0000_0080, ack after 3 cycles → stall 3 cycles, wb_data=0xFFFF_FF80.
- Store half addr 0x102, B=0xAAAA_BEEF → dmem_be=0011, wdata=0xBEEF_BEEF, dmem_addr=0x100, wb_write=0.
- Word load addr 0x101 with macro → no req, align_err=1, wb_write=0; without macro → dmem_addr=0x100.
- No ack, ACK_TIMEOUT=4 → req for 4 cycles, bus_err pulse, stall released.
- rst_n low during ACCESS → dmem_req=0 immediately; after release, new op completes normally.
